// File: rtl/asic_cfg_pkg.sv
// Mode codes, register and state types, and the addr/mode word builder
// shared by the front-end ASIC configuration sequencer.
package asic_cfg_pkg;

  localparam logic [2:0] TPLOCK      = 3'd0;
  localparam logic [2:0] PCAPMODE    = 3'd1;
  localparam logic [2:0] ONESHOTMODE = 3'd2;
  localparam logic [2:0] LOCKOUTMODE = 3'd3;
  localparam logic [2:0] DACMODE     = 3'd4;

  typedef enum logic [1:0] {
    PCAP    = 2'd0,
    ONESHOT = 2'd1,
    LOCKOUT = 2'd2,
    DAC     = 2'd3
  } cfg_reg_e;

  // Plain-vector state encoding so the values stay stable for older tooling.
  typedef logic [3:0] seq_state_e;
  localparam seq_state_e S_IDLE        = 4'd0;
  localparam seq_state_e S_GEN_DROP    = 4'd1;
  localparam seq_state_e S_AM_SETUP    = 4'd2;
  localparam seq_state_e S_AM_STB      = 4'd3;
  localparam seq_state_e S_PAY_SETUP   = 4'd4;
  localparam seq_state_e S_PAY_HOLD    = 4'd5;
  localparam seq_state_e S_PARK        = 4'd6;
  localparam seq_state_e S_GEN_RESTORE = 4'd7;
  localparam seq_state_e S_NULL        = 4'd8;

  function automatic logic [7:0] am_word(input logic [3:0] addr, input logic gmode,
                                         input logic [2:0] mode);
    am_word = {addr, gmode, mode};
  endfunction

  function automatic logic [2:0] reg_mode(input cfg_reg_e r);
    reg_mode = DACMODE;
    case (r)
      PCAP:    reg_mode = PCAPMODE;
      ONESHOT: reg_mode = ONESHOTMODE;
      LOCKOUT: reg_mode = LOCKOUTMODE;
      DAC:     reg_mode = DACMODE;
      default: reg_mode = DACMODE;
    endcase
  endfunction

endpackage

// File: rtl/asic_config_sequencer.sv
// Programs the ASIC per-channel registers over DATA/STB: one captured request,
// masked registers walked in fixed order, GEN held low around the sequence.
module asic_config_sequencer
  import asic_cfg_pkg::*;
#(
  parameter int DATABITS       = 8,
  parameter int SETUP_CYC      = 15,
  parameter int HOLD_CYC       = 15,
  parameter int GEN_SETTLE_CYC = 10
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                reqValid_i,
  output logic                reqReady_o,
  input  logic [3:0]          reqAddr_i,
  input  logic                reqGlobal_i,
  input  logic [3:0]          reqMask_i,
  input  logic [DATABITS-1:0] reqPcap_i,
  input  logic [DATABITS-1:0] reqOneshot_i,
  input  logic [DATABITS-1:0] reqLockout_i,
  input  logic [DATABITS-1:0] reqDac_i,
  input  logic                genReq_i,
  output logic [DATABITS-1:0] data_o,
  output logic                stb_o,
  output logic                gen_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int MAX_SH  = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int CNT_MAX = (MAX_SH > GEN_SETTLE_CYC) ? MAX_SH : GEN_SETTLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(GEN_SETTLE_CYC);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  seq_state_e               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  cfg_reg_e                 curReg_q, curReg_d;
  logic [3:0]               pend_q, pend_d, pendLeft;
  logic [3:0]               addr_q;
  logic                     gmode_q;
  logic [3:0][DATABITS-1:0] pay_q;
  logic                     accept;
  logic [DATABITS-1:0]      data_d, data_q;
  logic                     stb_d, stb_q, gen_d, gen_q, done_d, done_q, busy_q, ready_q;

  function automatic cfg_reg_e first_reg(input logic [3:0] m);
    if (m[0])      first_reg = PCAP;
    else if (m[1]) first_reg = ONESHOT;
    else if (m[2]) first_reg = LOCKOUT;
    else if (m[3]) first_reg = DAC;
    else           first_reg = PCAP;
  endfunction

  // Every state entry reloads the counter; a state is left when it reads 1.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    curReg_d = curReg_q;
    pend_d   = pend_q;
    pendLeft = pend_q & ~(4'b0001 << curReg_q);
    accept   = 1'b0;
    if (state_q == S_IDLE) begin
      if (reqValid_i && ready_q) begin
        accept   = 1'b1;
        pend_d   = reqMask_i;
        curReg_d = first_reg(reqMask_i);
        if (reqMask_i == 4'd0) begin
          state_d = S_NULL;
          cnt_d   = ONE;
        end else begin
          state_d = S_GEN_DROP;
          cnt_d   = SETTLE_LD;
        end
      end
    end else if (cnt_q != ONE) begin
      cnt_d = cnt_q - ONE;
    end else begin
      case (state_q)
        S_GEN_DROP:  begin state_d = S_AM_SETUP;  cnt_d = SETUP_LD; end
        S_AM_SETUP:  begin state_d = S_AM_STB;    cnt_d = SETUP_LD; end
        S_AM_STB:    begin state_d = S_PAY_SETUP; cnt_d = SETUP_LD; end
        S_PAY_SETUP: begin state_d = S_PAY_HOLD;  cnt_d = HOLD_LD;  end
        S_PAY_HOLD: begin
          pend_d = pendLeft;
          cnt_d  = SETUP_LD;
          if (pendLeft != 4'd0) begin
            curReg_d = first_reg(pendLeft);
            state_d  = S_AM_SETUP;
          end else begin
            state_d = S_PARK;
          end
        end
        S_PARK:      begin state_d = S_GEN_RESTORE; cnt_d = SETTLE_LD; end
        default:     begin state_d = S_IDLE;        cnt_d = '0;        end
      endcase
    end
  end

  // Outputs are decoded from the next state so the pins change with the state register.
  always_comb begin
    data_d = '0;
    case (state_d)
      S_AM_SETUP, S_AM_STB:    data_d[7:0] = am_word(addr_q, gmode_q, reg_mode(curReg_d));
      S_PAY_SETUP, S_PAY_HOLD: data_d      = pay_q[curReg_d];
      S_PARK:                  data_d[7:0] = am_word(4'd0, 1'b0, TPLOCK);
      default:                 data_d      = '0;
    endcase
    stb_d  = (state_d == S_AM_STB) || (state_d == S_PAY_SETUP);
    gen_d  = ((state_d == S_IDLE) || (state_d == S_NULL)) && genReq_i;
    done_d = (state_d == S_IDLE) && ((state_q == S_GEN_RESTORE) || (state_q == S_NULL));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      curReg_q <= PCAP;
      pend_q   <= '0;
      addr_q   <= '0;
      gmode_q  <= 1'b0;
      pay_q    <= '0;
      data_q   <= '0;
      stb_q    <= 1'b0;
      gen_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      curReg_q <= curReg_d;
      pend_q   <= pend_d;
      data_q   <= data_d;
      stb_q    <= stb_d;
      gen_q    <= gen_d;
      busy_q   <= (state_d != S_IDLE);
      done_q   <= done_d;
      ready_q  <= (state_d == S_IDLE);
      if (accept) begin
        addr_q  <= reqAddr_i;
        gmode_q <= reqGlobal_i;
        pay_q   <= {reqDac_i, reqLockout_i, reqOneshot_i, reqPcap_i};
      end
    end
  end

  assign data_o     = data_q;
  assign stb_o      = stb_q;
  assign gen_o      = gen_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign reqReady_o = ready_q;

endmodule

// File: tb/tb_asic_config_sequencer.sv
// Directed bench for asic_config_sequencer: each scenario task drives a request,
// records the bus trace and compares it against hand-computed expectations.
module tb_asic_config_sequencer;

  logic       clock;
  logic       reset;
  logic       reqValid;
  logic       reqReady;
  logic [3:0] reqAddr;
  logic       reqGlobal;
  logic [3:0] reqMask;
  logic [7:0] reqPcap, reqOneshot, reqLockout, reqDac;
  logic       genReq;
  logic [7:0] data;
  logic       stb, gen, busy, done;

  int nCmp = 0;
  int nBad = 0;

  int         doneCyc, doneCnt, stbRises, stbBadRuns, firstStbCyc;
  int         busyCnt, genBusyHi, genLowCnt, accept2Cyc;
  logic [7:0] dataLog[$];

  asic_config_sequencer dut (
    .clk_i        (clock),
    .rst_i        (reset),
    .reqValid_i   (reqValid),
    .reqReady_o   (reqReady),
    .reqAddr_i    (reqAddr),
    .reqGlobal_i  (reqGlobal),
    .reqMask_i    (reqMask),
    .reqPcap_i    (reqPcap),
    .reqOneshot_i (reqOneshot),
    .reqLockout_i (reqLockout),
    .reqDac_i     (reqDac),
    .genReq_i     (genReq),
    .data_o       (data),
    .stb_o        (stb),
    .gen_o        (gen),
    .busy_o       (busy),
    .done_o       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Called at a negedge with READY high; returns at the negedge after acceptance.
  task automatic issue(input logic [3:0] a, input logic g, input logic [3:0] m,
                       input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                       input logic [7:0] p3, input bit keepValid);
    reqAddr    = a;
    reqGlobal  = g;
    reqMask    = m;
    reqPcap    = p0;
    reqOneshot = p1;
    reqLockout = p2;
    reqDac     = p3;
    reqValid   = 1'b1;
    @(negedge clock);
    reqValid = keepValid;
  endtask

  // Records the bus trace for up to maxCyc cycles; cycle 0 is the one right after acceptance.
  task automatic capture(input int maxCyc, input int stbLen, input bit scramble, input bit stopOnReady);
    int         run;
    logic       prevStb;
    logic [7:0] prevData;
    doneCyc = -1; doneCnt = 0; stbRises = 0; stbBadRuns = 0; firstStbCyc = -1;
    busyCnt = 0; genBusyHi = 0; genLowCnt = 0; accept2Cyc = -1;
    dataLog.delete();
    dataLog.push_back(data);
    prevData = data;
    prevStb  = 1'b0;
    run      = 0;
    for (int c = 0; c < maxCyc; c++) begin
      if (c > 0 && data !== prevData) dataLog.push_back(data);
      if (stb) begin
        if (!prevStb) begin
          stbRises++;
          if (firstStbCyc < 0) firstStbCyc = c;
        end
        run++;
      end else if (prevStb) begin
        if (run != stbLen) stbBadRuns++;
        run = 0;
      end
      prevStb  = stb;
      prevData = data;
      if (done) begin
        doneCnt++;
        if (doneCyc < 0) doneCyc = c;
      end
      if (busy) begin
        busyCnt++;
        if (gen) genBusyHi++;
      end
      if (!gen) genLowCnt++;
      if (stopOnReady && c > 0 && reqReady && reqValid) begin
        accept2Cyc = c;
        break;
      end
      if (scramble) begin
        reqAddr    = 4'(c);
        reqGlobal  = 1'(c);
        reqMask    = 4'(c + 3);
        reqPcap    = 8'(c * 3);
        reqOneshot = 8'(c + 1);
        reqLockout = 8'(~c);
        reqDac     = 8'(c * 5);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    nCmp++; if (data !== 8'h00) begin nBad++; $display("[TB] FAIL reset_data: got %h want 00", data); end
    nCmp++; if (stb !== 1'b0) begin nBad++; $display("[TB] FAIL reset_stb: got %b want 0", stb); end
    nCmp++; if (gen !== 1'b0) begin nBad++; $display("[TB] FAIL reset_gen: got %b want 0", gen); end
    nCmp++; if (busy !== 1'b0) begin nBad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    nCmp++; if (done !== 1'b0) begin nBad++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    nCmp++; if (reqReady !== 1'b0) begin nBad++; $display("[TB] FAIL reset_ready: got %b want 0", reqReady); end
    reset = 1'b0;
    @(negedge clock);
    nCmp++; if (reqReady !== 1'b1) begin nBad++; $display("[TB] FAIL idle_ready: got %b want 1", reqReady); end
    nCmp++; if (gen !== 1'b1) begin nBad++; $display("[TB] FAIL idle_gen: got %b want 1", gen); end
    nCmp++; if (stb !== 1'b0) begin nBad++; $display("[TB] FAIL idle_stb: got %b want 0", stb); end
    nCmp++; if (data !== 8'h00) begin nBad++; $display("[TB] FAIL idle_data: got %h want 00", data); end
  endtask

  task automatic test_idle_gen();
    genReq = 1'b0;
    @(negedge clock);
    nCmp++; if (gen !== 1'b0) begin nBad++; $display("[TB] FAIL gen_follow_low: got %b want 0", gen); end
    genReq = 1'b1;
    @(negedge clock);
    nCmp++; if (gen !== 1'b1) begin nBad++; $display("[TB] FAIL gen_follow_high: got %b want 1", gen); end
  endtask

  task automatic test_full_broadcast();
    logic [7:0] expData [10];
    expData = '{8'h00, 8'h09, 8'h01, 8'h0A, 8'h26, 8'h0B, 8'h01, 8'h0C, 8'h6F, 8'h00};
    nCmp++; if (reqReady !== 1'b1) begin nBad++; $display("[TB] FAIL full_ready: got %b want 1", reqReady); end
    issue(4'h0, 1'b1, 4'hF, 8'h01, 8'h26, 8'h01, 8'h6F, 1'b0);
    capture(300, 30, 1'b0, 1'b0);
    nCmp++; if (dataLog.size() != 10) begin nBad++; $display("[TB] FAIL full_data_count: got %0d want 10", dataLog.size()); end
    for (int i = 0; i < 10 && i < dataLog.size(); i++) begin
      nCmp++;
      if (dataLog[i] !== expData[i]) begin nBad++; $display("[TB] FAIL full_data[%0d]: got %h want %h", i, dataLog[i], expData[i]); end
    end
    nCmp++; if (stbRises != 4) begin nBad++; $display("[TB] FAIL full_stb_pulses: got %0d want 4", stbRises); end
    nCmp++; if (stbBadRuns != 0) begin nBad++; $display("[TB] FAIL full_stb_width: got %0d bad pulses want 0", stbBadRuns); end
    nCmp++; if (firstStbCyc != 25) begin nBad++; $display("[TB] FAIL full_first_stb: got %0d want 25", firstStbCyc); end
    nCmp++; if (doneCyc != 275) begin nBad++; $display("[TB] FAIL full_done_cyc: got %0d want 275", doneCyc); end
    nCmp++; if (doneCnt != 1) begin nBad++; $display("[TB] FAIL full_done_count: got %0d want 1", doneCnt); end
    nCmp++; if (busyCnt != 275) begin nBad++; $display("[TB] FAIL full_busy_len: got %0d want 275", busyCnt); end
    nCmp++; if (genBusyHi != 0) begin nBad++; $display("[TB] FAIL full_gen_busy: got %0d want 0", genBusyHi); end
    nCmp++; if (gen !== 1'b1) begin nBad++; $display("[TB] FAIL full_gen_after: got %b want 1", gen); end
  endtask

  task automatic test_single_dac();
    logic [7:0] expData [4];
    expData = '{8'h00, 8'h54, 8'hA5, 8'h00};
    nCmp++; if (reqReady !== 1'b1) begin nBad++; $display("[TB] FAIL dac_ready: got %b want 1", reqReady); end
    issue(4'h5, 1'b0, 4'b1000, 8'h11, 8'h22, 8'h33, 8'hA5, 1'b0);
    capture(120, 30, 1'b0, 1'b0);
    nCmp++; if (dataLog.size() != 4) begin nBad++; $display("[TB] FAIL dac_data_count: got %0d want 4", dataLog.size()); end
    for (int i = 0; i < 4 && i < dataLog.size(); i++) begin
      nCmp++;
      if (dataLog[i] !== expData[i]) begin nBad++; $display("[TB] FAIL dac_data[%0d]: got %h want %h", i, dataLog[i], expData[i]); end
    end
    nCmp++; if (stbRises != 1) begin nBad++; $display("[TB] FAIL dac_stb_pulses: got %0d want 1", stbRises); end
    nCmp++; if (stbBadRuns != 0) begin nBad++; $display("[TB] FAIL dac_stb_width: got %0d bad pulses want 0", stbBadRuns); end
    nCmp++; if (doneCyc != 95) begin nBad++; $display("[TB] FAIL dac_done_cyc: got %0d want 95", doneCyc); end
    nCmp++; if (busyCnt != 95) begin nBad++; $display("[TB] FAIL dac_busy_len: got %0d want 95", busyCnt); end
  endtask

  task automatic test_empty_mask();
    nCmp++; if (reqReady !== 1'b1) begin nBad++; $display("[TB] FAIL empty_ready: got %b want 1", reqReady); end
    issue(4'h7, 1'b1, 4'b0000, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    capture(10, 30, 1'b0, 1'b0);
    nCmp++; if (doneCyc != 1) begin nBad++; $display("[TB] FAIL empty_done_cyc: got %0d want 1", doneCyc); end
    nCmp++; if (doneCnt != 1) begin nBad++; $display("[TB] FAIL empty_done_count: got %0d want 1", doneCnt); end
    nCmp++; if (busyCnt != 1) begin nBad++; $display("[TB] FAIL empty_busy_len: got %0d want 1", busyCnt); end
    nCmp++; if (stbRises != 0) begin nBad++; $display("[TB] FAIL empty_stb: got %0d pulses want 0", stbRises); end
    nCmp++; if (dataLog.size() != 1) begin nBad++; $display("[TB] FAIL empty_data_activity: got %0d values want 1", dataLog.size()); end
    nCmp++; if (genLowCnt != 0) begin nBad++; $display("[TB] FAIL empty_gen: got %0d low cycles want 0", genLowCnt); end
  endtask

  task automatic test_reset_abort();
    logic [7:0] expData [4];
    expData = '{8'h00, 8'h32, 8'h3C, 8'h00};
    issue(4'h1, 1'b0, 4'hF, 8'h10, 8'h26, 8'h30, 8'h40, 1'b0);
    repeat (105) @(negedge clock);
    nCmp++; if (stb !== 1'b1) begin nBad++; $display("[TB] FAIL abort_pre_stb: got %b want 1", stb); end
    nCmp++; if (data !== 8'h26) begin nBad++; $display("[TB] FAIL abort_pre_data: got %h want 26", data); end
    reset = 1'b1;
    @(negedge clock);
    nCmp++; if (stb !== 1'b0) begin nBad++; $display("[TB] FAIL abort_stb: got %b want 0", stb); end
    nCmp++; if (data !== 8'h00) begin nBad++; $display("[TB] FAIL abort_data: got %h want 00", data); end
    nCmp++; if (gen !== 1'b0) begin nBad++; $display("[TB] FAIL abort_gen: got %b want 0", gen); end
    nCmp++; if (busy !== 1'b0) begin nBad++; $display("[TB] FAIL abort_busy: got %b want 0", busy); end
    reset = 1'b0;
    @(negedge clock);
    nCmp++; if (reqReady !== 1'b1) begin nBad++; $display("[TB] FAIL abort_ready: got %b want 1", reqReady); end
    issue(4'h3, 1'b0, 4'b0010, 8'h00, 8'h3C, 8'h00, 8'h00, 1'b0);
    capture(120, 30, 1'b0, 1'b0);
    nCmp++; if (dataLog.size() != 4) begin nBad++; $display("[TB] FAIL abort_fresh_count: got %0d want 4", dataLog.size()); end
    for (int i = 0; i < 4 && i < dataLog.size(); i++) begin
      nCmp++;
      if (dataLog[i] !== expData[i]) begin nBad++; $display("[TB] FAIL abort_fresh_data[%0d]: got %h want %h", i, dataLog[i], expData[i]); end
    end
    nCmp++; if (doneCyc != 95) begin nBad++; $display("[TB] FAIL abort_fresh_done: got %0d want 95", doneCyc); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] expFirst [6];
    logic [7:0] expSecond [4];
    expFirst  = '{8'h00, 8'h99, 8'h5A, 8'h9B, 8'hC3, 8'h00};
    expSecond = '{8'h00, 8'h23, 8'h77, 8'h00};
    nCmp++; if (reqReady !== 1'b1) begin nBad++; $display("[TB] FAIL b2b_ready: got %b want 1", reqReady); end
    issue(4'h9, 1'b1, 4'b0101, 8'h5A, 8'hEE, 8'hC3, 8'hDD, 1'b1);
    capture(400, 30, 1'b1, 1'b1);
    nCmp++; if (dataLog.size() != 6) begin nBad++; $display("[TB] FAIL b2b_first_count: got %0d want 6", dataLog.size()); end
    for (int i = 0; i < 6 && i < dataLog.size(); i++) begin
      nCmp++;
      if (dataLog[i] !== expFirst[i]) begin nBad++; $display("[TB] FAIL b2b_first_data[%0d]: got %h want %h", i, dataLog[i], expFirst[i]); end
    end
    nCmp++; if (doneCyc != 155) begin nBad++; $display("[TB] FAIL b2b_first_done: got %0d want 155", doneCyc); end
    nCmp++; if (accept2Cyc != 155) begin nBad++; $display("[TB] FAIL b2b_accept_cyc: got %0d want 155", accept2Cyc); end
    issue(4'h2, 1'b0, 4'b0100, 8'h01, 8'h02, 8'h77, 8'h04, 1'b0);
    capture(120, 30, 1'b0, 1'b0);
    nCmp++; if (dataLog.size() != 4) begin nBad++; $display("[TB] FAIL b2b_second_count: got %0d want 4", dataLog.size()); end
    for (int i = 0; i < 4 && i < dataLog.size(); i++) begin
      nCmp++;
      if (dataLog[i] !== expSecond[i]) begin nBad++; $display("[TB] FAIL b2b_second_data[%0d]: got %h want %h", i, dataLog[i], expSecond[i]); end
    end
    nCmp++; if (doneCyc != 95) begin nBad++; $display("[TB] FAIL b2b_second_done: got %0d want 95", doneCyc); end
  endtask

  initial begin
    reset      = 1'b1;
    reqValid   = 1'b0;
    reqAddr    = 4'h0;
    reqGlobal  = 1'b0;
    reqMask    = 4'h0;
    reqPcap    = 8'h00;
    reqOneshot = 8'h00;
    reqLockout = 8'h00;
    reqDac     = 8'h00;
    genReq     = 1'b1;
    $display("[TB] starting asic_config_sequencer bench");
    test_reset();
    test_idle_gen();
    test_full_broadcast();
    test_single_dac();
    test_empty_mask();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
